// File: rtl/mips_pkg.sv
// Shared fetch-stage constants, the IF/ID register layout and a word-alignment helper.
// No logic of its own; imported by the fetch interface, pc_reg and fetch_unit.
package mips_pkg;

  localparam int                WORD_W    = 32;
  localparam logic [WORD_W-1:0] PC_STEP   = 32'd4;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: redirect/stall controls, instruction memory port and IF/ID outputs.
// jump_en/jump_target exist only when FETCH_JUMP_EN is defined.
interface fetch_if;
  import mips_pkg::*;

  logic              stall;
  logic              branch_taken;
  logic [WORD_W-1:0] branch_target;
`ifdef FETCH_JUMP_EN
  logic              jump_en;
  logic [WORD_W-1:0] jump_target;
`endif
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_instr;
  logic [WORD_W-1:0] if_id_instr;
  logic [WORD_W-1:0] if_id_pc_plus4;
  logic              if_id_valid;
  logic              pc_error;

  modport master (
`ifdef FETCH_JUMP_EN
    output jump_en, output jump_target,
`endif
    output stall, output branch_taken, output branch_target, output imem_instr,
    input  imem_addr, input if_id_instr, input if_id_pc_plus4, input if_id_valid,
    input  pc_error
  );

  modport slave (
`ifdef FETCH_JUMP_EN
    input  jump_en, input jump_target,
`endif
    input  stall, input branch_taken, input branch_target, input imem_instr,
    output imem_addr, output if_id_instr, output if_id_pc_plus4, output if_id_valid,
    output pc_error
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// PC register and next-PC select: branch > jump (FETCH_JUMP_EN) > stall > halt > PC+4.
// PC updates every edge; fault flags a misaligned redirect or a next PC beyond instruction memory.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                IMEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
`ifdef FETCH_JUMP_EN
  input  logic              jump_en,
  input  logic [WORD_W-1:0] jump_target,
`endif
  output logic [WORD_W-1:0] pc,
  output logic              redirect,
  output logic              halted,
  output logic              fault
);

  localparam logic [WORD_W-1:0] PC_LIMIT = WORD_W'(IMEM_WORDS * 4);

  logic [WORD_W-1:0] target;
  logic [WORD_W-1:0] pc_next;

  assign halted = (pc >= PC_LIMIT);

  always_comb begin
    redirect = 1'b0;
    target   = '0;
    pc_next  = pc;
    if (branch_taken) begin
      redirect = 1'b1;
      target   = branch_target;
    end
`ifdef FETCH_JUMP_EN
    else if (jump_en) begin
      redirect = 1'b1;
      target   = jump_target;
    end
`endif
    if (redirect)
      pc_next = word_align(target);
    else if (!stall && !halted)
      pc_next = pc + PC_STEP;
    // Flag on the edge that loads the bad PC, so pc_error rises together with it.
    fault = (redirect && (target[1:0] != 2'b00)) || (pc_next >= PC_LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IF/ID register and sticky pc_error; one edge from imem_addr to IF/ID.
// stall holds PC and IF/ID; a redirect overrides stall and loads a bubble. FETCH_JUMP_EN adds jumps.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                IMEM_WORDS = 64
) (
  input logic    clk,
  input logic    reset,
  fetch_if.slave bus
);

  logic [WORD_W-1:0] pc;
  logic              redirect;
  logic              halted;
  logic              fault;
  if_id_t            if_id_q;
  logic              pc_error_q;

  pc_reg #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .stall         (bus.stall),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
`ifdef FETCH_JUMP_EN
    .jump_en       (bus.jump_en),
    .jump_target   (bus.jump_target),
`endif
    .pc            (pc),
    .redirect      (redirect),
    .halted        (halted),
    .fault         (fault)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_q    <= IF_ID_BUBBLE;
      pc_error_q <= 1'b0;
    end else begin
      if (redirect || (!bus.stall && halted))
        if_id_q <= IF_ID_BUBBLE;
      else if (!bus.stall)
        if_id_q <= '{instr: bus.imem_instr, pc_plus4: pc + PC_STEP, valid: 1'b1};
      if (fault)
        pc_error_q <= 1'b1;
    end
  end

  assign bus.imem_addr      = pc;
  assign bus.if_id_instr    = if_id_q.instr;
  assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
  assign bus.if_id_valid    = if_id_q.valid;
  assign bus.pc_error       = pc_error_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference model pushes expected state per cycle, popped after each edge.
// Jump steps are compiled only when FETCH_JUMP_EN is defined.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam int          IMEM_WORDS = 64;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] LIMIT      = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        vld;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2010_0004 : (32'hAC00_0000 | a);
  endfunction

  assign bus.imem_instr = imem(bus.imem_addr);

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m = '{pc: RESET_PC, instr: NOP_INSTR, p4: 32'h0, vld: 1'b0, err: 1'b0};
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  bus.imem_addr, RESET_PC);
    chk({tag, "_instr"}, bus.if_id_instr, NOP_INSTR);
    chk({tag, "_p4"},    {31'h0, bus.if_id_pc_plus4 != 32'h0}, 32'h0);
    chk({tag, "_vld"},   {31'h0, bus.if_id_valid}, 32'h0);
    chk({tag, "_err"},   {31'h0, bus.pc_error}, 32'h0);
  endtask

  // Drive one cycle of controls and push what the stage must show after the next edge.
  task automatic drive(input logic st, input logic bt, input logic [31:0] btgt,
                       input logic je, input logic [31:0] jtgt);
    logic [31:0] tgt;
    bus.stall         = st;
    bus.branch_taken  = bt;
    bus.branch_target = btgt;
`ifdef FETCH_JUMP_EN
    bus.jump_en       = je;
    bus.jump_target   = jtgt;
`endif
    if (bt || je) begin
      tgt = bt ? btgt : jtgt;
      if (tgt[1:0] != 2'b00) m.err = 1'b1;
      m.pc    = {tgt[31:2], 2'b00};
      m.instr = NOP_INSTR; m.p4 = 32'h0; m.vld = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (m.pc >= LIMIT) begin
      m.instr = NOP_INSTR; m.p4 = 32'h0; m.vld = 1'b0;
    end else begin
      m.instr = imem(m.pc); m.p4 = m.pc + 32'd4; m.vld = 1'b1;
      m.pc    = m.pc + 32'd4;
    end
    if (m.pc >= LIMIT) m.err = 1'b1;
    sb.push_back(m);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_addr"},  bus.imem_addr, e.pc);
      chk({tag, "_instr"}, bus.if_id_instr, e.instr);
      chk({tag, "_p4"},    bus.if_id_pc_plus4, e.p4);
      chk({tag, "_vld"},   {31'h0, bus.if_id_valid}, {31'h0, e.vld});
      chk({tag, "_err"},   {31'h0, bus.pc_error}, {31'h0, e.err});
    end
  endtask

  task automatic run(input string tag);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(tag);
  endtask

  task automatic release_reset();
    drive_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive_idle();
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
`ifdef FETCH_JUMP_EN
    bus.jump_en = 1'b0; bus.jump_target = 32'h0;
`endif
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    model_reset();
    #1;
    chk_reset_vals("por");
    @(posedge clk); #1;
    chk_reset_vals("por_hold");
    release_reset();

    // First fetch: instruction at 0 lands in IF/ID one edge later.
    chk("r031_addr0", bus.imem_addr, 32'h0);
    run("r031");
    chk("r031_instr", bus.if_id_instr, 32'h2010_0004);
    chk("r031_p4",    bus.if_id_pc_plus4, 32'h4);
    chk("r031_addr4", bus.imem_addr, 32'h4);
    run("seq8");
    run("seqC");

    // Branch from 0xC to 0x38.
    drive(1'b0, 1'b1, 32'h38, 1'b0, 32'h0);
    tick("br38");
    chk("r032_addr", bus.imem_addr, 32'h38);
    chk("r032_instr", bus.if_id_instr, 32'h0);
    run("br38_next");
    chk("r032_p4", bus.if_id_pc_plus4, 32'h3C);
    chk("r032_vld", {31'h0, bus.if_id_valid}, 32'h1);

    // Stall at PC=0x10 with a real instruction held in IF/ID.
    drive(1'b0, 1'b1, 32'hC, 1'b0, 32'h0);
    tick("brC");
    run("toward10");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      tick("stall");
      chk("r033_addr", bus.imem_addr, 32'h10);
      chk("r033_instr", bus.if_id_instr, imem(32'hC));
    end
    drive(1'b1, 1'b1, 32'h20, 1'b0, 32'h0);
    tick("stall_br20");
    chk("r033_br_addr", bus.imem_addr, 32'h20);

    // Run off the end of instruction memory.
    drive(1'b0, 1'b1, 32'hE0, 1'b0, 32'h0);
    tick("brE0");
    for (int i = 0; i < 8; i++) run("toFC");
    chk("r034_addr", bus.imem_addr, 32'h100);
    chk("r034_err", {31'h0, bus.pc_error}, 32'h1);
    chk("r034_last_p4", bus.if_id_pc_plus4, 32'h100);
    for (int i = 0; i < 3; i++) begin
      run("halt");
      chk("r034_halt_vld", {31'h0, bus.if_id_valid}, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick("halt_stall");
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    tick("br0");
    run("after_halt");
    chk("r023_sticky", {31'h0, bus.pc_error}, 32'h1);

    // Reset mid-cycle with a stall and branch pending: both discarded.
    drive_idle();
    @(posedge clk); #3;
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h30;
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    @(posedge clk); #1;
    chk_reset_vals("rst_edge");
    model_reset();
    release_reset();
    run("resume0");
    chk("r026_instr", bus.if_id_instr, 32'h2010_0004);

    // Misaligned redirect, then asynchronous reset before the next edge.
    drive(1'b0, 1'b1, 32'h22, 1'b0, 32'h0);
    tick("br22");
    chk("r035_addr", bus.imem_addr, 32'h20);
    chk("r035_err", {31'h0, bus.pc_error}, 32'h1);
    run("after22");
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("r035_rst");
    model_reset();
    release_reset();
    run("post_rst");

`ifdef FETCH_JUMP_EN
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    tick("jmp40");
    chk("r036_jaddr", bus.imem_addr, 32'h40);
    run("jmp40_next");
    drive(1'b0, 1'b1, 32'h8, 1'b1, 32'h40);
    tick("br_over_jmp");
    chk("r036_baddr", bus.imem_addr, 32'h8);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h4);
    tick("jmp_over_stall");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
